// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin arbiter sharing one VRAM request port between
// master 0 (graphite rasterizer) and master 1 (host/display DMA).
// The granted master's bus is passed through combinationally; the grant is
// held until the slave acks or the master withdraws its request.
// Optional feature: define VRAM_ARB_TIMEOUT_EN to abort a grant after
// TIMEOUT cycles without ack (pulses the master's ack together with err_o).
module vram_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              m0_sel_i,
   input  logic              m0_wr_i,
   input  logic [3:0]        m0_mask_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   input  logic              m1_sel_i,
   input  logic              m1_wr_i,
   input  logic [3:0]        m1_mask_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic              m0_ack_o,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              vram_sel_o,
   output logic              vram_wr_o,
   output logic [3:0]        vram_mask_o,
   output logic [ADDR_W-1:0] vram_addr_o,
   output logic [DATA_W-1:0] vram_data_out_o,
   input  logic              vram_ack_i,
   input  logic [DATA_W-1:0] vram_data_in_i,
   output logic              busy_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state;
   logic   last;
   logic   gsel_c;
   logic   expire_c;

   // The abort counter is 8 bits wide; reject configurations it cannot reach.
   if (TIMEOUT > 255) begin : g_timeout_range
      $error("vram_arbiter: TIMEOUT must fit in 8 bits");
   end

   // Request line of whichever master currently holds the grant.
   always_comb begin
      gsel_c = 1'b0;
      case (state)
         GRANT0:  gsel_c = m0_sel_i;
         GRANT1:  gsel_c = m1_sel_i;
         default: gsel_c = 1'b0;
      endcase
   end

`ifdef VRAM_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Expiry only counts while the master still requests; a same-cycle ack wins.
   assign expire_c = gsel_c & ~vram_ack_i & (tmo_cnt == 8'(TIMEOUT));

   // Cycles spent in the current grant without an ack; zero while idle.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         tmo_cnt <= 8'd0;
      end else if (state == IDLE) begin
         tmo_cnt <= 8'd0;
      end else if (!vram_ack_i) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end
`else
   assign expire_c = 1'b0;
`endif

   // Grant FSM with round-robin pointer; last = 1 lets m0 win the first tie.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0_sel_i && (!m1_sel_i || last)) begin
                  state <= GRANT0;
                  last  <= 1'b0;
               end else if (m1_sel_i) begin
                  state <= GRANT1;
                  last  <= 1'b1;
               end
            end
            GRANT0, GRANT1: begin
               if (vram_ack_i || !gsel_c || expire_c) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Slave-side mux and ack routing; everything is zero outside a grant.
   always_comb begin
      vram_sel_o      = 1'b0;
      vram_wr_o       = 1'b0;
      vram_mask_o     = 4'd0;
      vram_addr_o     = '0;
      vram_data_out_o = '0;
      m0_ack_o        = 1'b0;
      m1_ack_o        = 1'b0;
      case (state)
         GRANT0: begin
            vram_sel_o      = m0_sel_i & ~expire_c;
            vram_wr_o       = m0_wr_i;
            vram_mask_o     = m0_mask_i;
            vram_addr_o     = m0_addr_i;
            vram_data_out_o = m0_data_i;
            m0_ack_o        = vram_ack_i | expire_c;
         end
         GRANT1: begin
            vram_sel_o      = m1_sel_i & ~expire_c;
            vram_wr_o       = m1_wr_i;
            vram_mask_o     = m1_mask_i;
            vram_addr_o     = m1_addr_i;
            vram_data_out_o = m1_data_i;
            m1_ack_o        = vram_ack_i | expire_c;
         end
         default: ;
      endcase
   end

   assign m_data_o = vram_data_in_i;
   assign busy_o   = (state != IDLE);
   assign err_o    = expire_c;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a transaction-level reference model of the arbiter.
module tb_vram_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 16;
`ifdef VRAM_ARB_TIMEOUT_EN
   localparam int TO_EN = 1;
   localparam int TO    = 8;
`else
   localparam int TO_EN = 0;
   localparam int TO    = 255;
`endif

   logic              clk;
   logic              reset_i;
   logic              m0_sel_i, m1_sel_i;
   logic              m0_wr_i, m1_wr_i;
   logic [3:0]        m0_mask_i, m1_mask_i;
   logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
   logic [DATA_W-1:0] m0_data_i, m1_data_i;
   logic              m0_ack_o, m1_ack_o;
   logic [DATA_W-1:0] m_data_o;
   logic              vram_sel_o, vram_wr_o;
   logic [3:0]        vram_mask_o;
   logic [ADDR_W-1:0] vram_addr_o;
   logic [DATA_W-1:0] vram_data_out_o;
   logic              vram_ack_i;
   logic [DATA_W-1:0] vram_data_in_i;
   logic              busy_o, err_o;

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_i(reset_i),
      .m0_sel_i(m0_sel_i), .m0_wr_i(m0_wr_i), .m0_mask_i(m0_mask_i),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
      .m1_sel_i(m1_sel_i), .m1_wr_i(m1_wr_i), .m1_mask_i(m1_mask_i),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
      .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o), .m_data_o(m_data_o),
      .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
      .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o),
      .vram_ack_i(vram_ack_i), .vram_data_in_i(vram_data_in_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus (-1 none), tie-break pointer, wait count.
   int mg    = -1;
   bit mlast = 1'b1;
   int mcnt  = 0;

   int ack0_cnt = 0;
   int ack1_cnt = 0;
   bit a0 = 1'b0;
   bit a1 = 1'b0;
   int grant_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Settle, compare every output with the model, then advance one clock.
   task automatic cycle();
      logic gs, ex;
      #1;
      gs = (mg == 0) ? m0_sel_i : (mg == 1) ? m1_sel_i : 1'b0;
      ex = (TO_EN == 1) && (mg >= 0) && gs && !vram_ack_i && (mcnt == TO);
      chk("vram_sel",  64'(vram_sel_o), 64'(gs && !ex));
      chk("vram_wr",   64'(vram_wr_o),  64'((mg == 0) ? m0_wr_i : (mg == 1) ? m1_wr_i : 1'b0));
      chk("vram_mask", 64'(vram_mask_o), 64'((mg == 0) ? m0_mask_i : (mg == 1) ? m1_mask_i : 4'd0));
      chk("vram_addr", 64'(vram_addr_o), 64'((mg == 0) ? m0_addr_i : (mg == 1) ? m1_addr_i : 32'd0));
      chk("vram_data", 64'(vram_data_out_o), 64'((mg == 0) ? m0_data_i : (mg == 1) ? m1_data_i : 16'd0));
      chk("m0_ack",    64'(m0_ack_o), 64'((mg == 0) && (vram_ack_i || ex)));
      chk("m1_ack",    64'(m1_ack_o), 64'((mg == 1) && (vram_ack_i || ex)));
      chk("m_data",    64'(m_data_o), 64'(vram_data_in_i));
      chk("busy",      64'(busy_o),   64'(mg >= 0));
      chk("err",       64'(err_o),    64'(ex));
      a0 = m0_ack_o;
      a1 = m1_ack_o;
      if (a0) begin ack0_cnt++; grant_log.push_back(0); end
      if (a1) begin ack1_cnt++; grant_log.push_back(1); end
      if (reset_i) begin
         mg = -1; mlast = 1'b1; mcnt = 0;
      end else if (mg < 0) begin
         mcnt = 0;
         if (m0_sel_i && (!m1_sel_i || mlast)) begin mg = 0; mlast = 1'b0; end
         else if (m1_sel_i) begin mg = 1; mlast = 1'b1; end
      end else if (vram_ack_i || !gs || ex) begin
         mg = -1;
      end else begin
         mcnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      m0_sel_i = 0; m0_wr_i = 0; m0_mask_i = 0; m0_addr_i = 0; m0_data_i = 0;
      m1_sel_i = 0; m1_wr_i = 0; m1_mask_i = 0; m1_addr_i = 0; m1_data_i = 0;
      vram_ack_i = 0; vram_data_in_i = 0;
   endtask

   task automatic do_reset();
      quiet();
      reset_i = 1'b1;
      cycle();
      cycle();
      reset_i = 1'b0;
   endtask

   initial begin
      int b0, b1, guard;
      int exp_order[6] = '{0, 1, 0, 1, 0, 1};
      reset_i = 1'b1;
      quiet();
      @(posedge clk);
      #1;
      do_reset();

      // Reset state
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_sel",  64'(vram_sel_o), 64'd0);

      // Single master read of 0x100, slave acks after 3 waiting cycles
      b0 = ack0_cnt; b1 = ack1_cnt;
      m0_sel_i = 1; m0_wr_i = 0; m0_addr_i = 32'h100;
      cycle();
      chk("rd_sel_latency", 64'(vram_sel_o), 64'd1);
      for (int i = 0; i < 3; i++) cycle();
      vram_ack_i = 1; vram_data_in_i = 16'hBEEF;
      #1;
      chk("rd_data", 64'(m_data_o), 64'hBEEF);
      chk("rd_ack",  64'(m0_ack_o), 64'd1);
      cycle();
      quiet();
      cycle();
      chk("rd_ack0_pulses", 64'(ack0_cnt - b0), 64'd1);
      chk("rd_ack1_pulses", 64'(ack1_cnt - b1), 64'd0);

      // Contention after reset: continuous requests alternate 0,1,0,1,0,1
      do_reset();
      grant_log.delete();
      m0_sel_i = 1; m0_addr_i = 32'hA0;
      m1_sel_i = 1; m1_addr_i = 32'hB0;
      guard = 0;
      while (grant_log.size() < 6 && guard < 60) begin
         #1;
         vram_ack_i = vram_sel_o;
         cycle();
         guard++;
      end
      quiet();
      cycle();
      chk("rr_count", 64'(grant_log.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_order[%0d]", i),
             64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_order[i]));

      // Write passthrough from m1
      m1_sel_i = 1; m1_wr_i = 1; m1_mask_i = 4'h3; m1_addr_i = 32'h2A; m1_data_i = 16'h1234;
      cycle();
      for (int i = 0; i < 2; i++) begin
         chk("wr_wr",   64'(vram_wr_o), 64'd1);
         chk("wr_mask", 64'(vram_mask_o), 64'h3);
         chk("wr_addr", 64'(vram_addr_o), 64'h2A);
         chk("wr_data", 64'(vram_data_out_o), 64'h1234);
         cycle();
      end
      vram_ack_i = 1;
      cycle();
      quiet();
      #1;
      chk("wr_after_sel",  64'(vram_sel_o), 64'd0);
      chk("wr_after_wr",   64'(vram_wr_o), 64'd0);
      chk("wr_after_addr", 64'(vram_addr_o), 64'd0);
      chk("wr_after_data", 64'(vram_data_out_o), 64'd0);
      cycle();

      // Stray ack while idle
      b0 = ack0_cnt; b1 = ack1_cnt;
      vram_ack_i = 1;
      cycle();
      cycle();
      vram_ack_i = 0;
      cycle();
      chk("stray_acks", 64'((ack0_cnt - b0) + (ack1_cnt - b1)), 64'd0);
      chk("stray_busy", 64'(busy_o), 64'd0);

      // Reset in the middle of a GRANT1
      m1_sel_i = 1; m1_addr_i = 32'h77;
      cycle();
      cycle();
      chk("mid_busy_before", 64'(busy_o), 64'd1);
      reset_i = 1;
      cycle();
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      chk("mid_rst_sel",  64'(vram_sel_o), 64'd0);
      chk("mid_rst_addr", 64'(vram_addr_o), 64'd0);
      chk("mid_rst_ack1", 64'(m1_ack_o), 64'd0);
      reset_i = 0;
      m1_sel_i = 0;
      cycle();
      m0_sel_i = 1; m0_addr_i = 32'h55;
      m1_sel_i = 1;
      cycle();
      vram_ack_i = 1;
      #1;
      chk("mid_then_m0", 64'(m0_ack_o), 64'd1);
      cycle();
      quiet();
      cycle();

`ifdef VRAM_ARB_TIMEOUT_EN
      // Slave never acks: abort after 8 waiting cycles
      m0_sel_i = 1; m0_addr_i = 32'h300;
      cycle();
      for (int i = 0; i < 8; i++) cycle();
      #1;
      chk("to_err",  64'(err_o), 64'd1);
      chk("to_ack",  64'(m0_ack_o), 64'd1);
      chk("to_sel",  64'(vram_sel_o), 64'd0);
      cycle();
      quiet();
      cycle();
      // Ack exactly at expiry completes normally
      m0_sel_i = 1;
      cycle();
      for (int i = 0; i < 8; i++) cycle();
      vram_ack_i = 1;
      #1;
      chk("to_race_err", 64'(err_o), 64'd0);
      chk("to_race_ack", 64'(m0_ack_o), 64'd1);
      chk("to_race_sel", 64'(vram_sel_o), 64'd1);
      cycle();
      quiet();
      cycle();
`endif

      // Randomized traffic with occasional withdrawals and resets
      for (int n = 0; n < 3000; n++) begin
         if (a0) m0_sel_i = 0;
         else if (m0_sel_i && ($urandom % 64 == 0)) m0_sel_i = 0;
         else if (!m0_sel_i && ($urandom % 4 == 0)) begin
            m0_sel_i = 1; m0_wr_i = 1'($urandom); m0_mask_i = 4'($urandom);
            m0_addr_i = $urandom; m0_data_i = 16'($urandom);
         end
         if (a1) m1_sel_i = 0;
         else if (m1_sel_i && ($urandom % 64 == 0)) m1_sel_i = 0;
         else if (!m1_sel_i && ($urandom % 4 == 0)) begin
            m1_sel_i = 1; m1_wr_i = 1'($urandom); m1_mask_i = 4'($urandom);
            m1_addr_i = $urandom; m1_data_i = 16'($urandom);
         end
         vram_ack_i     = ($urandom % 3 == 0);
         vram_data_in_i = 16'($urandom);
         reset_i        = ($urandom % 300 == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-master arbiter that shares the single VRAM request port between the `graphite` rasterizer (master 0) and a second requester (master 1, host/display DMA). It sits between those masters and the VRAM controller. Each master sees a private copy of the VRAM bus, and the arbiter grants one request at a time, round-robin, holding the grant until the slave acknowledges.

## Interface
Parameters:
- `ADDR_W`, 32, VRAM address width
- `DATA_W`, 16, VRAM data width
- `TIMEOUT`, 255, cycles without ack before abort (active only with `VRAM_ARB_TIMEOUT_EN`); 8-bit counter

Ports:
- `clk` in 1: single clock; all logic on its rising edge
- `reset_i` in 1: synchronous, active-high reset
- `m0_sel_i`, `m1_sel_i` in 1: master request, held until that master's ack
- `m0_wr_i`, `m1_wr_i` in 1: 1 = write, 0 = read
- `m0_mask_i`, `m1_mask_i` in 4: write byte/nibble mask
- `m0_addr_i`, `m1_addr_i` in ADDR_W: address
- `m0_data_i`, `m1_data_i` in DATA_W: write data
- `m0_ack_o`, `m1_ack_o` out 1: one-cycle completion pulse to the granted master
- `m_data_o` out DATA_W: read data, broadcast to both masters
- `vram_sel_o`, `vram_wr_o` out 1; `vram_mask_o` out 4; `vram_addr_o` out ADDR_W; `vram_data_out_o` out DATA_W: slave request
- `vram_ack_i` in 1; `vram_data_in_i` in DATA_W: slave completion and read data
- `busy_o` out 1: a grant is active
- `err_o` out 1: one-cycle pulse on timeout abort

## Operation
- States: IDLE, GRANT0, GRANT1. Pointer `last` (1 bit) records the most recent grant.
- IDLE:
  - Only m0 requesting → GRANT0. Only m1 requesting → GRANT1.
  - Both requesting → grant `!last`.
  - Neither requesting → stay in IDLE.
  - On any grant, `last` is updated.
- GRANTn:
  - `vram_*` outputs are driven combinationally from master n. `vram_sel_o = mn_sel_i`.
  - `mn_ack_o = vram_ack_i`. The other master's ack is forced to 0.
- Leaving GRANTn for IDLE:
  - On `vram_ack_i`.
  - If `mn_sel_i` drops without an ack (protocol violation): return to IDLE, no ack issued.
- Outside GRANTn: all `vram_*` outputs are 0, both acks are 0, and `vram_ack_i` is ignored (stray or late acks are dropped).
- `m_data_o = vram_data_in_i` at all times. It is valid only in the ack cycle.
- `busy_o = (state != IDLE)`.
- Reset: state IDLE, `last = 1` (m0 wins the first contention). All outputs read 0 after the reset edge, including mid-transaction; any in-flight slave access is abandoned.

## Timing
- Request latency: request sampled at edge N in IDLE → `vram_sel_o` high in cycle N+1.
- Ack is passed through in the same cycle (zero latency). State is IDLE after that edge.
- There is one mandatory IDLE cycle between consecutive grants. Back-to-back requests from the same master therefore achieve 1 access per (slave latency + 2) cycles.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Masters must hold `sel`/`wr`/`mask`/`addr`/`data` stable until ack. The arbiter does not register them.

## Configuration
- `VRAM_ARB_TIMEOUT_EN` defined:
  - A counter clears on grant and increments each GRANT cycle without `vram_ack_i`.
  - When the counter reaches `TIMEOUT`, that cycle forces `vram_sel_o` low, pulses `mn_ack_o` and `err_o` for one cycle, and returns to IDLE.
  - `m_data_o` is undefined on an aborted read.
  - An ack in the same cycle as expiry wins: normal completion, no `err_o`.
- Not defined: no counter, `err_o` tied to 0, and a grant is held indefinitely until ack.

## Test plan
- **Single master read:** m0 reads addr 0x100; slave acks 3 cycles after sel with data 0xBEEF → `vram_sel_o` rises 1 cycle after request; `m0_ack_o` pulses once; `m_data_o` = 0xBEEF; `m1_ack_o` stays 0.
- **Contention after reset:** m0 and m1 request in the same cycle → m0 is served first, then m1 after one IDLE cycle. Under continuous requests, the grant order over 6 accesses is 0,1,0,1,0,1.
- **Write passthrough:** m1 writes addr 0x2A, mask 0x3, data 0x1234 → `vram_wr_o` = 1, `vram_mask_o` = 0x3, `vram_addr_o` = 0x2A, `vram_data_out_o` = 0x1234 held until ack; then all `vram_*` return to 0.
- **Stray ack:** `vram_ack_i` pulsed while in IDLE → no master ack, state unchanged.
- **Reset mid-grant:** `reset_i` asserted during GRANT1 before ack → next cycle all outputs are 0 and state is IDLE. A later contention grants m0 first.
- **Timeout (with `VRAM_ARB_TIMEOUT_EN`, TIMEOUT = 8):** slave never acks → after 8 GRANT cycles `m0_ack_o` and `err_o` pulse together and `vram_sel_o` drops. Repeat with the ack arriving exactly at expiry → normal completion, `err_o` = 0.
